program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32: program memory capacity in 32-bit words; maximum loadable word count.
REQ-002 Parameter BASE_ADDR, default 32'h0040_0000: byte address of the first program word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_i  input  1  one-cycle request to begin a new load.
REQ-006 byte_valid_i  input  1  byte_data_i holds a valid byte.
REQ-007 byte_data_i  input  8  serial program byte stream.
REQ-008 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 prog_we_o  output  1  program memory write strobe, one cycle per word.
REQ-010 prog_addr_o  output  32  byte address of the word being written.
REQ-011 prog_data_o  output  32  assembled instruction word.
REQ-012 cpu_reset_o  output  1  holds the processor in reset while high.
REQ-013 done_o  output  1  load completed successfully.
REQ-014 error_o  output  1  load aborted because of an illegal length.

Function
REQ-015 The FSM SHALL use states IDLE, LEN, DATA, WRITE, DONE and ERROR.
REQ-016 A byte transfer SHALL occur only on a cycle with byte_valid_i && byte_ready_o.
REQ-017 byte_ready_o SHALL be high only in LEN and DATA.
REQ-018 Byte order SHALL be big-endian: the first byte of each 4-byte group goes to bits 31:24 and the fourth goes to bits 7:0.
REQ-019 In IDLE, DONE or ERROR, start_i SHALL move the FSM to LEN and clear the word counter and byte counter; start_i SHALL be ignored in LEN, DATA and WRITE.
REQ-020 LEN SHALL accept 4 bytes forming the word count N.
REQ-021 After the fourth LEN byte: N == 0 goes to DONE, N > MEMORY_DEPTH goes to ERROR, otherwise the FSM goes to DATA.
REQ-022 In DATA, the fourth byte of a word accepted on cycle t SHALL move the FSM to WRITE, and prog_we_o SHALL be high on cycle t+1 only.
REQ-023 In WRITE, prog_data_o SHALL equal the assembled word, and prog_addr_o SHALL equal BASE_ADDR + 4*k, where k is the 0-based word index (32-bit unsigned, wrap ignored).
REQ-024 WRITE SHALL last exactly one cycle and then go to DONE if k == N-1, else to DATA with k incremented.
REQ-025 prog_we_o SHALL be low in every state except WRITE; prog_addr_o and prog_data_o SHALL hold their last values outside WRITE.
REQ-026 cpu_reset_o SHALL be low only in DONE.
REQ-027 done_o SHALL be high only in DONE, and error_o high only in ERROR.
REQ-028 Gaps of any length between bytes (byte_valid_i low) SHALL NOT alter state or partial words.
REQ-029 Bytes presented while byte_ready_o is low SHALL be neither consumed nor stored.

Reset
REQ-030 Reset SHALL force state IDLE, all counters 0, the assembly register 0, prog_we_o=0, prog_addr_o=BASE_ADDR, prog_data_o=0, byte_ready_o=0, done_o=0, error_o=0 and cpu_reset_o=1.
REQ-031 Reset asserted mid-load SHALL abandon the partial word with no further prog_we_o pulse, and a subsequent start_i SHALL restart from LEN.

Structure
REQ-032 FSM state encodings and BYTES_PER_WORD (4) SHALL live in the shared package/include file loader_pkg.
REQ-033 Byte-to-word assembly (shift register plus 2-bit byte counter with a word_valid pulse) SHALL be the sub-module word_assembler, instantiated once and used for both LEN and DATA.
REQ-034 The block SHALL be synthesizable with no latches; all registers SHALL use the same asynchronous active-high reset.

Verification
REQ-035 start_i, then bytes 00 00 00 02 | 20 08 00 05 | 21 29 00 01 -> two prog_we_o pulses: (0x0040_0000, 0x2008_0005) then (0x0040_0004, 0x2129_0001); done_o=1; cpu_reset_o=0.
REQ-036 Same stream with byte_valid_i low for 3 random cycles between every byte -> identical writes and final state.
REQ-037 Length bytes 00 00 00 21 with MEMORY_DEPTH=32 -> error_o=1, no prog_we_o pulse, cpu_reset_o=1, byte_ready_o=0.
REQ-038 Length 00 00 00 00 -> DONE immediately after the fourth byte, no prog_we_o pulse.
REQ-039 Reset asserted after 2 of the 4 bytes of word 1 -> all outputs return to reset values immediately, no write occurs; a new start_i with a 1-word load writes at 0x0040_0000.
REQ-040 start_i pulsed while in DATA -> ignored, and the load completes normally; start_i in DONE -> cpu_reset_o=1 on the next cycle and the FSM is in LEN.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: FSM encoding, word geometry
// and the program-memory address helper.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  // Byte address of word idx; wraps silently at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * 32'(BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write bus of the loader.
interface program_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        prog_we_o;
  logic [31:0] prog_addr_o;
  logic [31:0] prog_data_o;

  modport slave (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, prog_we_o, prog_addr_o, prog_data_o
  );

  modport master (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, prog_we_o, prog_addr_o, prog_data_o
  );
endinterface

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler; word_valid_o flags the cycle the last byte
// of a word is accepted, with word_o already including that byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int SHW = 8 * (BYTES_PER_WORD - 1);

  logic [SHW-1:0]        shift_q;
  logic [BYTE_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_en_i) begin
      shift_q <= {shift_q[SHW-9:0], byte_i};
      cnt_q   <= cnt_q + BYTE_CNT_W'(1);
    end
  end

  // Only the leading bytes are stored; the final byte is combined in flight.
  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_en_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian word stream into program memory and
// releases the processor from reset once the whole image is written.
module program_loader
  import loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  program_loader_if.slave  ldr_if,
  output logic             cpu_reset_o,
  output logic             done_o,
  output logic             error_o
);

  state_e      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        asm_clr;
  logic        accept;
  logic [31:0] word;
  logic        word_valid;

  assign ldr_if.byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA);
  assign accept              = ldr_if.byte_valid_i && ldr_if.byte_ready_o;

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (asm_clr),
    .byte_en_i    (accept),
    .byte_i       (ldr_if.byte_data_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    asm_clr = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_LEN;
          idx_d   = '0;
          asm_clr = 1'b1;
        end
      end
      S_LEN: begin
        if (word_valid) begin
          len_d = word;
          if (word == 32'd0)                     state_d = S_DONE;
          else if (word > 32'(MEMORY_DEPTH))     state_d = S_ERROR;
          else                                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Address/data are latched here so they stay stable outside WRITE.
        if (word_valid) begin
          state_d = S_WRITE;
          data_d  = word;
          addr_d  = word_addr(BASE_ADDR, idx_q);
        end
      end
      S_WRITE: begin
        if (idx_q == len_q - 32'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
          idx_d   = idx_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ldr_if.prog_we_o   = (state_q == S_WRITE);
  assign ldr_if.prog_addr_o = addr_q;
  assign ldr_if.prog_data_o = data_q;
  assign cpu_reset_o        = (state_q != S_DONE);
  assign done_o             = (state_q == S_DONE);
  assign error_o            = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal load, gapped stream, length
// limits, mid-load reset and start_i handling.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_reset, done, error;

  program_loader_if bus();

  program_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .ldr_if      (bus),
    .cpu_reset_o (cpu_reset),
    .done_o      (done),
    .error_o     (error)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Write capture, sampled on the falling edge.
  int          wr_n = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  always @(negedge clk) begin
    if (bus.prog_we_o && wr_n < 64) begin
      wr_addr[wr_n] = bus.prog_addr_o;
      wr_data[wr_n] = bus.prog_data_o;
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      bus.byte_valid_i = 1'b0;
      bus.byte_data_i  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    n = 0;
    while (!bus.byte_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("byte_ready_timeout", {31'd0, bus.byte_ready_o}, 32'd1);
    @(posedge clk); #1;
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int w0;
    reset            = 1'b1;
    start            = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;

    // Reset state
    #2;
    chk("rst_we",    {31'd0, bus.prog_we_o},    32'd0);
    chk("rst_addr",  bus.prog_addr_o,           BASE);
    chk("rst_data",  bus.prog_data_o,           32'd0);
    chk("rst_ready", {31'd0, bus.byte_ready_o}, 32'd0);
    chk("rst_cpu",   {31'd0, cpu_reset},        32'd1);
    chk("rst_done",  {31'd0, done},             32'd0);
    chk("rst_err",   {31'd0, error},            32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Basic two-word load
    w0 = wr_n;
    pulse_start();
    chk("t1_ready_len", {31'd0, bus.byte_ready_o}, 32'd1);
    send_word(32'd2, 0);
    send_word(32'h2008_0005, 0);
    send_word(32'h2129_0001, 0);
    wait_end();
    @(posedge clk); #1;
    chk("t1_nwr",  32'(wr_n - w0),   32'd2);
    chk("t1_a0",   wr_addr[w0],      BASE);
    chk("t1_d0",   wr_data[w0],      32'h2008_0005);
    chk("t1_a1",   wr_addr[w0+1],    BASE + 32'd4);
    chk("t1_d1",   wr_data[w0+1],    32'h2129_0001);
    chk("t1_done", {31'd0, done},    32'd1);
    chk("t1_cpu",  {31'd0, cpu_reset}, 32'd0);
    chk("t1_hold_addr", bus.prog_addr_o, BASE + 32'd4);
    chk("t1_hold_data", bus.prog_data_o, 32'h2129_0001);

    // Same stream with 3-cycle gaps, restarted from DONE
    w0 = wr_n;
    pulse_start();
    send_word(32'd2, 3);
    send_word(32'h2008_0005, 3);
    send_word(32'h2129_0001, 3);
    wait_end();
    chk("t2_nwr",  32'(wr_n - w0),   32'd2);
    chk("t2_a0",   wr_addr[w0],      BASE);
    chk("t2_d0",   wr_data[w0],      32'h2008_0005);
    chk("t2_a1",   wr_addr[w0+1],    BASE + 32'd4);
    chk("t2_d1",   wr_data[w0+1],    32'h2129_0001);
    chk("t2_done", {31'd0, done},    32'd1);
    chk("t2_cpu",  {31'd0, cpu_reset}, 32'd0);

    // Length 33 exceeds depth
    w0 = wr_n;
    pulse_start();
    send_word(32'd33, 0);
    @(posedge clk); #1;
    chk("t3_err",   {31'd0, error},            32'd1);
    chk("t3_done",  {31'd0, done},             32'd0);
    chk("t3_cpu",   {31'd0, cpu_reset},        32'd1);
    chk("t3_ready", {31'd0, bus.byte_ready_o}, 32'd0);
    chk("t3_nwr",   32'(wr_n - w0),            32'd0);

    // Length 0 finishes right after the fourth byte
    w0 = wr_n;
    pulse_start();
    send_word(32'd0, 0);
    chk("t4_done", {31'd0, done},      32'd1);
    chk("t4_cpu",  {31'd0, cpu_reset}, 32'd0);
    chk("t4_err",  {31'd0, error},     32'd0);
    @(posedge clk); #1;
    chk("t4_nwr",  32'(wr_n - w0),     32'd0);

    // Length 32 is legal; reset after 2 bytes of the first word
    w0 = wr_n;
    pulse_start();
    send_word(32'd32, 0);
    chk("t5_err",   {31'd0, error},            32'd0);
    chk("t5_ready", {31'd0, bus.byte_ready_o}, 32'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_we",    {31'd0, bus.prog_we_o},    32'd0);
    chk("t5_rst_ready", {31'd0, bus.byte_ready_o}, 32'd0);
    chk("t5_rst_addr",  bus.prog_addr_o,           BASE);
    chk("t5_rst_data",  bus.prog_data_o,           32'd0);
    chk("t5_rst_cpu",   {31'd0, cpu_reset},        32'd1);
    chk("t5_rst_done",  {31'd0, done},             32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t5_nwr_rst", 32'(wr_n - w0), 32'd0);
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'hDEAD_BEEF, 0);
    wait_end();
    chk("t5_nwr",  32'(wr_n - w0), 32'd1);
    chk("t5_a0",   wr_addr[w0],    BASE);
    chk("t5_d0",   wr_data[w0],    32'hDEAD_BEEF);
    chk("t5_done", {31'd0, done},  32'd1);

    // start_i ignored during DATA, honoured in DONE
    w0 = wr_n;
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start();
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_word(32'h5566_7788, 0);
    wait_end();
    chk("t6_nwr",  32'(wr_n - w0),  32'd2);
    chk("t6_a0",   wr_addr[w0],     BASE);
    chk("t6_d0",   wr_data[w0],     32'h1122_3344);
    chk("t6_a1",   wr_addr[w0+1],   BASE + 32'd4);
    chk("t6_d1",   wr_data[w0+1],   32'h5566_7788);
    chk("t6_done", {31'd0, done},   32'd1);
    pulse_start();
    chk("t6_cpu_len",   {31'd0, cpu_reset},        32'd1);
    chk("t6_done_len",  {31'd0, done},             32'd0);
    chk("t6_ready_len", {31'd0, bus.byte_ready_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
